// File: rtl/tt_sweep_pkg.sv
// Shared types and default constants for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int DEFAULT_N_IN        = 3;
    localparam int DEFAULT_HOLD_CYCLES = 10;

    // Counter width able to hold the settle count; never below one bit.
    function automatic int hold_width(input int hold_cycles);
        int w;
        w = $clog2(hold_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tt_sweep_hold_timer.sv
// Settle-time down-counter: clear loads LOAD_VALUE, en counts toward zero,
// tc flags the last settle cycle.
module tt_hold_timer #(
    parameter int LOAD_VALUE = 9,
    parameter int WIDTH      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = WIDTH'(LOAD_VALUE);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_controller.sv
// Clocked exhaustive sweep of a 3-input combinational block: drives every
// input vector in order, waits a settle time, and packs x/y into truth tables.
module tt_sweep_controller
    import tt_sweep_pkg::*;
#(
    parameter int N_IN        = DEFAULT_N_IN,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    localparam int N_VEC      = 2 ** N_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             x_in,
    input  logic             y_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic [N_IN-1:0]  vec_idx,
    output logic             sample_valid,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] result_x,
    output logic [N_VEC-1:0] result_y
);

    localparam int HOLD_W = hold_width(HOLD_CYCLES);

    sweep_state_t     state_q, state_d;
    logic [N_IN-1:0]  vec_idx_q, vec_idx_d;
    logic             sample_valid_q, sample_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N_VEC-1:0] result_x_q, result_x_d;
    logic [N_VEC-1:0] result_y_q, result_y_d;

    logic timer_clear;
    logic timer_en;
    logic timer_tc;
    logic res_clear;
    logic capture;

    // Loaded with HOLD_CYCLES-1 on entry to DRIVE so DRIVE lasts HOLD_CYCLES cycles.
    tt_hold_timer #(
        .LOAD_VALUE (HOLD_CYCLES - 1),
        .WIDTH      (HOLD_W)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        res_clear   = 1'b0;
        capture     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    vec_idx_d   = '0;
                    timer_clear = 1'b1;
                    res_clear   = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end
            end
            DRIVE: begin
                timer_en = 1'b1;
                if (timer_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                capture = 1'b1;
                if (vec_idx_q == N_IN'(N_VEC - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d     = DRIVE;
                    vec_idx_d   = vec_idx_q + N_IN'(1);
                    timer_clear = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pulse is registered alongside the state so it is high exactly in SAMPLE.
    assign sample_valid_d = (state_d == SAMPLE);

    for (genvar gi = 0; gi < N_VEC; gi++) begin : g_result
        assign result_x_d[gi] = res_clear ? 1'b0 :
                                (capture && (vec_idx_q == N_IN'(gi))) ? x_in : result_x_q[gi];
        assign result_y_d[gi] = res_clear ? 1'b0 :
                                (capture && (vec_idx_q == N_IN'(gi))) ? y_in : result_y_q[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            vec_idx_q      <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_x_q     <= '0;
            result_y_q     <= '0;
        end else begin
            state_q        <= state_d;
            vec_idx_q      <= vec_idx_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_x_q     <= result_x_d;
            result_y_q     <= result_y_d;
        end
    end

    // a/b/c are wired straight from the index register, so {a,b,c} always equals vec_idx.
    assign a            = vec_idx_q[N_IN-1];
    assign b            = vec_idx_q[N_IN-2];
    assign c            = vec_idx_q[0];
    assign vec_idx      = vec_idx_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_x     = result_x_q;
    assign result_y     = result_y_q;

endmodule
